// File: rtl/anim_sequencer_if.sv
// -----------------------------------------------------------------------------
// anim_sequencer_if
// Direct-select request channel into the animation sequencer.
//   req_valid : requester has an animation ID to show
//   req_id    : requested animation ID (ID_W bits)
//   req_ready : sequencer can take a request this cycle
// The master modport is the requester; the slave modport is the sequencer.
// -----------------------------------------------------------------------------
interface anim_sequencer_if #(
   parameter int ID_W = 2
);
   logic            req_valid;
   logic [ID_W-1:0] req_id;
   logic            req_ready;

   modport master (output req_valid, output req_id, input req_ready);
   modport slave  (input req_valid, input req_id, output req_ready);
endinterface

// File: rtl/anim_sequencer.sv
// -----------------------------------------------------------------------------
// anim_sequencer
// Chooses which animation ROM feeds pixel words to the SPI LCD driver. A go
// rising edge steps to the next animation, a direct request selects a given ID,
// and every switch is held back until the next frame boundary so the panel
// never tears. A non-idle animation falls back to IDLE_ID after
// TIMEOUT_FRAMES complete frames (0 disables the fallback).
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   req            : request channel (slave side)
//   go             : level input, rising edge steps the animation
//   lcd_addr_x/y   : pixel address currently requested by the LCD driver
//   anim_data      : all animation pixel words, source k at [k*PIX_W +: PIX_W]
//   ram_data       : pixel word of the displayed animation (combinational)
//   cur_anim       : displayed animation ID
//   pending        : a switch is waiting for the next frame boundary
//   frame_tick     : registered one-cycle pulse marking a new frame
// -----------------------------------------------------------------------------
module anim_sequencer #(
   parameter int NUM_ANIM       = 4,
   parameter int PIX_W          = 16,
   parameter int ID_W           = 2,
   parameter int IDLE_ID        = 0,
   parameter int TIMEOUT_FRAMES = 600,
   parameter int CNT_W          = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   anim_sequencer_if.slave           req,
   input  logic                      go,
   input  logic [7:0]                lcd_addr_x,
   input  logic [7:0]                lcd_addr_y,
   input  logic [NUM_ANIM*PIX_W-1:0] anim_data,
   output logic [PIX_W-1:0]          ram_data,
   output logic [ID_W-1:0]           cur_anim,
   output logic                      pending,
   output logic                      frame_tick
);

   typedef enum logic {SHOW, PENDING} state_t;

   localparam logic [ID_W:0]    NUM_ANIM_X = (ID_W+1)'(NUM_ANIM);
   localparam logic [ID_W-1:0]  LAST_ID    = ID_W'(NUM_ANIM - 1);
   localparam logic [ID_W-1:0]  IDLE       = ID_W'(IDLE_ID);
   localparam bit               TO_EN      = (TIMEOUT_FRAMES != 0);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_FRAMES - 1);

   state_t           state, state_next;
   logic [ID_W-1:0]  target, target_next;
   logic [ID_W-1:0]  cur_next;
   logic [CNT_W-1:0] frame_cnt, cnt_next;
   logic             go_d;
   logic [7:0]       prev_x, prev_y;
   logic             go_rise;
   logic             frame_start;
   logic             req_in_range;

   // A frame begins when the driver arrives at (0,0) from any other address;
   // the driver may dwell on (0,0) for several cycles, which must count once.
   // prev_x/prev_y reset to 8'hFF so the very first (0,0) after reset counts.
   assign frame_start  = (lcd_addr_x == 8'd0) && (lcd_addr_y == 8'd0) &&
                         !((prev_x == 8'd0) && (prev_y == 8'd0));
   assign go_rise      = go && !go_d;
   assign req_in_range = ({1'b0, req.req_id} < NUM_ANIM_X);

   assign pending       = (state == PENDING);
   assign req.req_ready = (state == SHOW);

   // Pixel mux: zero latency so the driver sees the new animation on the same
   // edge cur_anim changes. Scanning the sources avoids indexing past NUM_ANIM
   // when ID_W has spare codes.
   always_comb begin
      ram_data = '0;
      for (int k = 0; k < NUM_ANIM; k++) begin
         if (cur_anim == ID_W'(k)) begin
            ram_data = anim_data[k*PIX_W +: PIX_W];
         end
      end
   end

   // Next-state logic. In SHOW a request beats go, and go beats the timeout
   // count; an out-of-range request is swallowed but still blocks the lower
   // priorities that cycle. The timeout return happens directly because it is
   // evaluated at a frame boundary already. In PENDING everything waits for
   // the boundary, where the latched target is applied and the frame count
   // restarts, even when the target equals the current animation.
   always_comb begin
      state_next  = state;
      target_next = target;
      cur_next    = cur_anim;
      cnt_next    = frame_cnt;
      case (state)
         SHOW: begin
            if (req.req_valid) begin
               if (req_in_range) begin
                  target_next = req.req_id;
                  state_next  = PENDING;
               end
            end else if (go_rise) begin
               target_next = (cur_anim == LAST_ID) ? {ID_W{1'b0}} : cur_anim + 1'b1;
               state_next  = PENDING;
            end else if (frame_start && TO_EN && (cur_anim != IDLE)) begin
               if (frame_cnt == TO_LAST) begin
                  cur_next = IDLE;
                  cnt_next = '0;
               end else begin
                  cnt_next = frame_cnt + 1'b1;
               end
            end
         end
         PENDING: begin
            if (frame_start) begin
               cur_next   = target;
               cnt_next   = '0;
               state_next = SHOW;
            end
         end
         default: begin
            state_next = SHOW;
         end
      endcase
   end

   // State register and the registered side signals. frame_tick is the
   // registered copy of frame_start, so it rises on the same edge that
   // applies a pending switch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= SHOW;
         cur_anim   <= IDLE;
         target     <= IDLE;
         frame_cnt  <= '0;
         frame_tick <= 1'b0;
         go_d       <= 1'b0;
         prev_x     <= 8'hFF;
         prev_y     <= 8'hFF;
      end else begin
         state      <= state_next;
         cur_anim   <= cur_next;
         target     <= target_next;
         frame_cnt  <= cnt_next;
         frame_tick <= frame_start;
         go_d       <= go;
         prev_x     <= lcd_addr_x;
         prev_y     <= lcd_addr_y;
      end
   end

endmodule

// File: doc/anim_sequencer.md
Name: anim_sequencer

Overview:
- Parametrised pixel-source sequencer between NUM_ANIM animation ROM blocks and the SPI LCD driver.
- Selects which animation's pixel word drives the LCD RAM-data bus. Accepts two kinds of request: a go pulse that steps to the next animation, and a direct request for a specific ID.
- Applies every switch only at a frame boundary, so the panel never shows a tear.
- Returns automatically to the idle animation after a programmable number of frames.

Parameters:
NUM_ANIM, 4, number of animation sources (2..16)
PIX_W, 16, pixel word width (RGB565)
ID_W, 2, animation ID width; must satisfy 2**ID_W >= NUM_ANIM
IDLE_ID, 0, animation selected at reset and on timeout
TIMEOUT_FRAMES, 600, full frames a non-idle animation is shown before auto-return; 0 disables auto-return
CNT_W, 16, frame counter width; must hold TIMEOUT_FRAMES

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
go  in  1  level input; a rising edge is detected internally and steps the animation
req_valid  in  1  direct-select request valid
req_id  in  ID_W  requested animation ID
req_ready  out  1  request accepted when req_valid && req_ready at posedge
lcd_addr_x  in  8  current pixel column from LCD driver
lcd_addr_y  in  8  current pixel row from LCD driver
anim_data  in  NUM_ANIM*PIX_W  concatenated pixel words; source k occupies bits [k*PIX_W +: PIX_W]
ram_data  out  PIX_W  pixel word to LCD driver
cur_anim  out  ID_W  animation currently displayed
pending  out  1  a switch is latched and waiting for a frame boundary
frame_tick  out  1  one-cycle pulse, registered, one cycle after frame_start

Behaviour:
- Reset values: cur_anim=IDLE_ID, state=SHOW, pending=0, target=IDLE_ID, frame_tick=0, frame_cnt=0, go_d=0, prev_x=prev_y=8'hFF.
- With these reset values, the first (0,0) address after reset produces a frame_start.
- ram_data = anim_data slice selected by cur_anim. Purely combinational, zero latency, same as the idle/happy mux it replaces.
- go_rise = go && !go_d. go_d is a register.
- frame_start (comb) = (lcd_addr_x==0 && lcd_addr_y==0) && !(prev_x==0 && prev_y==0). prev_x and prev_y are registered every cycle.
- frame_tick <= frame_start.
- State machine has two states, SHOW and PENDING. pending=(state==PENDING). req_ready=(state==SHOW).
- SHOW, resolved in priority order req > go > timeout:
  - req_valid with req_id < NUM_ANIM: target<=req_id, go to PENDING.
  - req_valid with req_id >= NUM_ANIM: accepted and discarded; state unchanged.
  - else go_rise: target<=(cur_anim==NUM_ANIM-1)?0:cur_anim+1, go to PENDING.
  - else frame_start && TIMEOUT_FRAMES!=0 && cur_anim!=IDLE_ID:
    - if frame_cnt==TIMEOUT_FRAMES-1: cur_anim<=IDLE_ID, frame_cnt<=0. Already at a boundary, so no PENDING.
    - else frame_cnt<=frame_cnt+1.
  - When req or go is accepted, the timeout action is suppressed that cycle.
- PENDING:
  - go_rise is ignored. req_ready=0, so no request is accepted.
  - On frame_start: cur_anim<=target, frame_cnt<=0, go to SHOW.
  - A target equal to cur_anim is legal: the switch still completes and resets frame_cnt, which restarts the timeout.
- Visible result: a non-idle animation is shown for exactly TIMEOUT_FRAMES complete frames after its switch, then idle.
- cur_anim, and therefore ram_data, changes on the same clock edge at which frame_tick rises.
- Reset asserted mid-operation: all registers return to reset values immediately. Any latched target is lost.
- frame_cnt never wraps. It is compared and cleared before it can exceed TIMEOUT_FRAMES-1.

Test Plan:
- Reset, then scan frames with NUM_ANIM=4 and anim_data = {16'h4444,16'h3333,16'h2222,16'h1111} → cur_anim=0, ram_data=16'h1111, pending=0, req_ready=1.
- go pulse mid-frame at (x=40,y=70) → pending=1 and ram_data stays 16'h1111 until address (0,0). At that edge cur_anim=1 and ram_data=16'h2222; frame_tick pulses one cycle later than frame_start. Four go pulses across four frames → 1,2,3,0 (wrap).
- req_valid with req_id=3 and go_rise in the same cycle → request wins, target=3. Second req_id=2 while pending → req_ready=0, not accepted. After boundary cur_anim=3.
- TIMEOUT_FRAMES=3, switch to ID 2 → ID 2 stays through 3 full frames. At the 3rd following frame_start, cur_anim=0 without pending asserting. TIMEOUT_FRAMES=0 → ID 2 remains indefinitely.
- req_id=5 with ID_W=3 and NUM_ANIM=4 → accepted for one cycle (req_ready=1), no pending, cur_anim unchanged.
- Assert rst asynchronously while pending=1 and target=2 → outputs reset immediately, cur_anim=0, and ID 2 is never displayed after release.
